// File: rtl/axis_converter_signals_pkg.sv
// Shared AXI4-Stream default sideband values and beat sizing helper for the
// sideband normaliser and its register slice.
package axis_converter_signals_pkg;

  // Per-byte keep value; replicate to the keep width at the point of use.
  localparam logic KEEP_ALL_ONES  = 1'b1;
  localparam logic LAST_DEFAULT   = 1'b1;
  localparam logic WAKEUP_DEFAULT = 1'b1;

  // Total width of one beat: tdata, tkeep, tstrb, tlast, tid, tdest, tuser, twakeup.
  function automatic int beat_width(input int data_width, input int tid_width,
                                    input int dest_width, input int user_width);
    return data_width + 2 * (data_width / 8) + 1 + tid_width + dest_width
           + user_width + 1;
  endfunction

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry registered skid buffer: a main register drives the master side and a
// skid register catches the beat accepted in the cycle the master stalls.
module axis_skid_buffer #(
  parameter int Width = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [Width-1:0] s_data,
  input  logic             s_valid,
  output logic             s_ready,
  output logic [Width-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready
);

  logic [Width-1:0] main_q, main_d;
  logic [Width-1:0] skid_q, skid_d;
  logic             main_valid_q, main_valid_d;
  logic             skid_valid_q, skid_valid_d;
  logic             ready_q;
  logic             s_xfer, m_xfer;

  assign s_xfer = s_valid & ready_q;
  assign m_xfer = main_valid_q & m_ready;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    main_d       = main_q;
    main_valid_d = main_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    if (!main_valid_q || m_xfer) begin
      // Main is free this edge: the skid beat goes first to keep FIFO order.
      if (skid_valid_q) begin
        main_d       = skid_q;
        main_valid_d = 1'b1;
        skid_valid_d = 1'b0;
      end else begin
        main_valid_d = s_xfer;
        if (s_xfer) main_d = s_data;
      end
    end else if (s_xfer) begin
      skid_d       = s_data;
      skid_valid_d = 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  // NOTE: payload registers are reset too, because the master payload must read zero in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q       <= '0;
      skid_q       <= '0;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      ready_q      <= 1'b0;
    end else begin
      main_q       <= main_d;
      skid_q       <= skid_d;
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      ready_q      <= ~skid_valid_d;
    end
  end

  assign s_ready = ready_q;
  assign m_data  = main_q;
  assign m_valid = main_valid_q;

endmodule

// File: rtl/axis_converter_signals.sv
// AXI4-Stream sideband normaliser: fills unconnected slave sideband signals with
// AXIS defaults and drives a full-width master through a registered skid buffer.
module axis_converter_signals
  import axis_converter_signals_pkg::*;
#(
  parameter int DataWidth        = 32,
  parameter int TidWidth         = 8,
  parameter int DestWidth        = 8,
  parameter int UserWidthPerByte = 1,
  parameter bit KeepEnable       = 1'b1,
  parameter bit StrbEnable       = 1'b1,
  parameter bit LastEnable       = 1'b1,
  parameter bit IdEnable         = 1'b1,
  parameter bit DestEnable       = 1'b1,
  parameter bit UserEnable       = 1'b1,
  parameter bit WakeupEnable     = 1'b1,
  parameter bit ReadyEnable      = 1'b1,
  localparam int KeepWidth       = DataWidth / 8,
  localparam int UserWidth       = UserWidthPerByte * KeepWidth
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DataWidth-1:0] s_axis_tdata,
  input  logic [KeepWidth-1:0] s_axis_tkeep,
  input  logic [KeepWidth-1:0] s_axis_tstrb,
  input  logic                 s_axis_tvalid,
  output logic                 s_axis_tready,
  input  logic                 s_axis_tlast,
  input  logic [TidWidth-1:0]  s_axis_tid,
  input  logic [DestWidth-1:0] s_axis_tdest,
  input  logic [UserWidth-1:0] s_axis_tuser,
  input  logic                 s_axis_twakeup,
  output logic [DataWidth-1:0] m_axis_tdata,
  output logic [KeepWidth-1:0] m_axis_tkeep,
  output logic [KeepWidth-1:0] m_axis_tstrb,
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready,
  output logic                 m_axis_tlast,
  output logic [TidWidth-1:0]  m_axis_tid,
  output logic [DestWidth-1:0] m_axis_tdest,
  output logic [UserWidth-1:0] m_axis_tuser,
  output logic                 m_axis_twakeup
);

  localparam int BeatWidth = beat_width(DataWidth, TidWidth, DestWidth, UserWidth);

  typedef struct packed {
    logic [DataWidth-1:0] tdata;
    logic [KeepWidth-1:0] tkeep;
    logic [KeepWidth-1:0] tstrb;
    logic                 tlast;
    logic [TidWidth-1:0]  tid;
    logic [DestWidth-1:0] tdest;
    logic [UserWidth-1:0] tuser;
    logic                 twakeup;
  } beat_t;

  beat_t                s_beat;
  beat_t                m_beat;
  logic [BeatWidth-1:0] m_vec;
  logic                 m_ready_eff;

  // Constant selects: a disabled input is never looked at, so X on it cannot leak.
  assign s_beat.tdata   = s_axis_tdata;
  assign s_beat.tkeep   = KeepEnable   ? s_axis_tkeep   : {KeepWidth{KEEP_ALL_ONES}};
  assign s_beat.tstrb   = StrbEnable   ? s_axis_tstrb   : s_beat.tkeep;
  assign s_beat.tlast   = LastEnable   ? s_axis_tlast   : LAST_DEFAULT;
  assign s_beat.tid     = IdEnable     ? s_axis_tid     : '0;
  assign s_beat.tdest   = DestEnable   ? s_axis_tdest   : '0;
  assign s_beat.tuser   = UserEnable   ? s_axis_tuser   : '0;
  assign s_beat.twakeup = WakeupEnable ? s_axis_twakeup : WAKEUP_DEFAULT;
  assign m_ready_eff    = ReadyEnable  ? m_axis_tready  : 1'b1;

  axis_skid_buffer #(
    .Width (BeatWidth)
  ) u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .s_data  (s_beat),
    .s_valid (s_axis_tvalid),
    .s_ready (s_axis_tready),
    .m_data  (m_vec),
    .m_valid (m_axis_tvalid),
    .m_ready (m_ready_eff)
  );

  assign m_beat         = beat_t'(m_vec);
  assign m_axis_tdata   = m_beat.tdata;
  assign m_axis_tkeep   = m_beat.tkeep;
  assign m_axis_tstrb   = m_beat.tstrb;
  assign m_axis_tlast   = m_beat.tlast;
  assign m_axis_tid     = m_beat.tid;
  assign m_axis_tdest   = m_beat.tdest;
  assign m_axis_tuser   = m_beat.tuser;
  assign m_axis_twakeup = m_beat.twakeup;

endmodule

// File: tb/tb_axis_converter_signals.sv
// Directed bench: one fully-connected converter and one with every optional
// sideband (and master ready) disabled, sharing clock and reset.
module tb_axis_converter_signals;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Fully connected instance.
  logic [31:0] s_tdata;
  logic [3:0]  s_tkeep, s_tstrb, s_tuser;
  logic        s_tvalid, s_tready, s_tlast, s_twakeup;
  logic [7:0]  s_tid, s_tdest;
  logic [31:0] m_tdata;
  logic [3:0]  m_tkeep, m_tstrb, m_tuser;
  logic        m_tvalid, m_tready, m_tlast, m_twakeup;
  logic [7:0]  m_tid, m_tdest;

  // Instance with all sidebands and master ready tied off.
  logic [31:0] d_s_tdata;
  logic [3:0]  d_s_tkeep, d_s_tstrb, d_s_tuser;
  logic        d_s_tvalid, d_s_tready, d_s_tlast, d_s_twakeup;
  logic [7:0]  d_s_tid, d_s_tdest;
  logic [31:0] d_m_tdata;
  logic [3:0]  d_m_tkeep, d_m_tstrb, d_m_tuser;
  logic        d_m_tvalid, d_m_tready, d_m_tlast, d_m_twakeup;
  logic [7:0]  d_m_tid, d_m_tdest;

  axis_converter_signals dut (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tstrb(s_tstrb),
    .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready), .s_axis_tlast(s_tlast),
    .s_axis_tid(s_tid), .s_axis_tdest(s_tdest), .s_axis_tuser(s_tuser),
    .s_axis_twakeup(s_twakeup),
    .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tstrb(m_tstrb),
    .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready), .m_axis_tlast(m_tlast),
    .m_axis_tid(m_tid), .m_axis_tdest(m_tdest), .m_axis_tuser(m_tuser),
    .m_axis_twakeup(m_twakeup)
  );

  axis_converter_signals #(
    .KeepEnable(1'b0), .StrbEnable(1'b0), .LastEnable(1'b0), .IdEnable(1'b0),
    .DestEnable(1'b0), .UserEnable(1'b0), .WakeupEnable(1'b0), .ReadyEnable(1'b0)
  ) dut_def (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tdata(d_s_tdata), .s_axis_tkeep(d_s_tkeep), .s_axis_tstrb(d_s_tstrb),
    .s_axis_tvalid(d_s_tvalid), .s_axis_tready(d_s_tready), .s_axis_tlast(d_s_tlast),
    .s_axis_tid(d_s_tid), .s_axis_tdest(d_s_tdest), .s_axis_tuser(d_s_tuser),
    .s_axis_twakeup(d_s_twakeup),
    .m_axis_tdata(d_m_tdata), .m_axis_tkeep(d_m_tkeep), .m_axis_tstrb(d_m_tstrb),
    .m_axis_tvalid(d_m_tvalid), .m_axis_tready(d_m_tready), .m_axis_tlast(d_m_tlast),
    .m_axis_tid(d_m_tid), .m_axis_tdest(d_m_tdest), .m_axis_tuser(d_m_tuser),
    .m_axis_twakeup(d_m_twakeup)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] q[$];
  logic [31:0] held;
  logic [31:0] exp_data;
  bit          stalled;
  bit          acc;
  int          low_run;
  int          sent;
  int          recv;

  initial begin
    s_tdata = '0; s_tkeep = 4'hF; s_tstrb = 4'hF; s_tvalid = 1'b0; s_tlast = 1'b0;
    s_tid = '0; s_tdest = '0; s_tuser = '0; s_twakeup = 1'b0; m_tready = 1'b0;
    d_s_tdata = '0; d_s_tkeep = 'x; d_s_tstrb = 'x; d_s_tvalid = 1'b0; d_s_tlast = 'x;
    d_s_tid = 'x; d_s_tdest = 'x; d_s_tuser = 'x; d_s_twakeup = 'x; d_m_tready = 1'b0;

    // Reset held for two cycles.
    step();
    step();
    check("rst_m_tvalid", m_tvalid, 1'b0);
    check("rst_s_tready", s_tready, 1'b0);
    check("rst_m_tdata", m_tdata, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("rst_release_s_tready", s_tready, 1'b1);
    check("rst_release_def_s_tready", d_s_tready, 1'b1);

    // Streaming: ten beats, continuous ready, sidebands passed through.
    m_tready = 1'b1;
    s_tid = 8'h3C; s_tdest = 8'hC3; s_tuser = 4'h5; s_tkeep = 4'h7; s_tstrb = 4'h3;
    for (int i = 0; i < 10; i++) begin
      s_tvalid = 1'b1;
      s_tdata  = 32'(i);
      s_tlast  = (i == 9);
      step();
      check("stream_valid", m_tvalid, 1'b1);
      check("stream_data", m_tdata, 64'(i));
      check("stream_last", m_tlast, (i == 9));
      check("stream_s_tready", s_tready, 1'b1);
    end
    check("pass_tid", m_tid, 8'h3C);
    check("pass_tdest", m_tdest, 8'hC3);
    check("pass_tuser", m_tuser, 4'h5);
    check("pass_tkeep", m_tkeep, 4'h7);
    check("pass_tstrb", m_tstrb, 4'h3);
    check("pass_twakeup", m_twakeup, 1'b0);
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    step();
    check("stream_idle", m_tvalid, 1'b0);

    // Backpressure: m_tready toggles every cycle with valid held high.
    s_tvalid = 1'b1;
    s_tdata  = 32'd100;
    stalled  = 1'b0;
    low_run  = 0;
    sent     = 0;
    recv     = 0;
    for (int c = 0; c < 24; c++) begin
      m_tready = (c % 2 == 0);
      if (stalled) begin
        check("bp_hold_valid", m_tvalid, 1'b1);
        check("bp_hold_data", m_tdata, held);
      end
      if (m_tvalid && m_tready) begin
        if (q.size() == 0) begin
          check("bp_spurious_beat", 1'b1, 1'b0);
        end else begin
          exp_data = q.pop_front();
          check("bp_order", m_tdata, exp_data);
        end
        recv++;
      end
      stalled = m_tvalid && !m_tready;
      held    = m_tdata;
      acc     = s_tvalid && s_tready;
      if (acc) q.push_back(s_tdata);
      low_run = s_tready ? 0 : low_run + 1;
      check("bp_ready_low_max1", (low_run <= 1), 1'b1);
      step();
      if (acc) begin
        sent++;
        s_tdata = s_tdata + 32'd1;
      end
    end
    s_tvalid = 1'b0;
    m_tready = 1'b1;
    for (int c = 0; c < 10 && q.size() > 0; c++) begin
      if (m_tvalid) begin
        exp_data = q.pop_front();
        check("bp_drain_order", m_tdata, exp_data);
        recv++;
      end
      step();
    end
    check("bp_queue_empty", 64'(q.size()), 64'd0);
    check("bp_count", 64'(recv), 64'(sent));
    check("bp_progress", (sent >= 12), 1'b1);
    check("bp_idle_after", m_tvalid, 1'b0);

    // Defaults: inputs X and master ready low must not matter.
    d_s_tvalid = 1'b1;
    d_s_tdata  = 32'hA5A5_0001;
    step();
    check("def_valid", d_m_tvalid, 1'b1);
    check("def_data", d_m_tdata, 32'hA5A5_0001);
    check("def_tkeep", d_m_tkeep, 4'hF);
    check("def_tstrb", d_m_tstrb, 4'hF);
    check("def_tlast", d_m_tlast, 1'b1);
    check("def_tid", d_m_tid, 8'h00);
    check("def_tdest", d_m_tdest, 8'h00);
    check("def_tuser", d_m_tuser, 4'h0);
    check("def_twakeup", d_m_twakeup, 1'b1);
    d_s_tdata = 32'hA5A5_0002;
    step();
    check("def_ready_ignored", d_m_tdata, 32'hA5A5_0002);
    d_s_tvalid = 1'b0;

    // Mid-packet reset with both registers full.
    m_tready = 1'b0;
    s_tvalid = 1'b1;
    s_tdata  = 32'h11;
    s_tlast  = 1'b0;
    step();
    s_tdata = 32'h22;
    s_tlast = 1'b1;
    step();
    s_tvalid = 1'b0;
    check("full_s_tready", s_tready, 1'b0);
    check("full_m_data", m_tdata, 32'h11);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", m_tvalid, 1'b0);
    check("async_rst_s_tready", s_tready, 1'b0);
    check("async_rst_data", m_tdata, 32'h0);
    check("async_rst_last", m_tlast, 1'b0);
    step();
    step();
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("rerst_s_tready", s_tready, 1'b1);
    check("rerst_m_tvalid", m_tvalid, 1'b0);
    m_tready = 1'b1;
    s_tvalid = 1'b1;
    s_tdata  = 32'h33;
    s_tlast  = 1'b0;
    step();
    s_tvalid = 1'b0;
    check("rerst_first_valid", m_tvalid, 1'b1);
    check("rerst_first_data", m_tdata, 32'h33);
    step();
    check("rerst_no_stale", m_tvalid, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
